// File: rtl/pdp8_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : pdp8_bus_responder
// Description : Far-end responder for the PDP-8 CPU's 8-bit multiplexed
//               external bus. It assembles a 12-bit address from two 6-bit
//               halves and builds 12-bit write words from three 4-bit nibbles.
//               It returns read data to the CPU one nibble at a time. Each data
//               access goes either to a synchronous 4K x 12 SRAM port or to a
//               selected 12-bit I/O device.
//
//               Bus decode of cpu_out:
//                 [7]   A : 1 = address phase, 0 = data phase / I/O select
//                 [6]   H : address half select (1 = upper six bits)
//                 [6:5] F : nibble field (00 hi, 01 mid, 10 lo + commit,
//                           11 = I/O select when A = 0)
//                 [4]   S : active-low write strobe (I/O select bit when F=11)
//                 [3:0]   : write nibble
//
// Ports       : clk        - clock
//               rst        - synchronous active-high reset
//               cpu_out    - CPU bus outputs
//               cpu_din    - nibble returned to the CPU (combinational)
//               mem_addr   - SRAM address (registered)
//               mem_rdata  - SRAM read data, valid one cycle after mem_addr
//               mem_we     - SRAM write enable, one-cycle pulse
//               mem_wdata  - SRAM write data
//               io_mode    - 1 = data phase targets the I/O port
//               io_sel     - selected I/O device
//               io_rd      - one-cycle pulse following an I/O select
//               io_rdata   - device read data, sampled while io_rd is high
//               io_wr      - one-cycle device write pulse
//               io_wdata   - device write data
//
// Revision    : 1.0 - initial release
// ============================================================================
module pdp8_bus_responder #(
    parameter int AW    = 12,   // fixed at 12 for the PDP-8
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       cpu_out,
    output logic [3:0]       cpu_din,
    output logic [AW-1:0]    mem_addr,
    input  logic [11:0]      mem_rdata,
    output logic             mem_we,
    output logic [11:0]      mem_wdata,
    output logic             io_mode,
    output logic [SEL_W-1:0] io_sel,
    output logic             io_rd,
    input  logic [11:0]      io_rdata,
    output logic             io_wr,
    output logic [11:0]      io_wdata
);

    localparam logic [1:0] c_F_HI  = 2'b00;
    localparam logic [1:0] c_F_MID = 2'b01;
    localparam logic [1:0] c_F_LO  = 2'b10;
    localparam logic [1:0] c_F_SEL = 2'b11;

    // ------------------------------------------------------------------
    // Bus field decode
    // ------------------------------------------------------------------
    logic       w_addr_phase;
    logic       w_addr_hi;
    logic [1:0] w_field;
    logic       w_strobe_n;
    logic [3:0] w_nibble;
    logic       w_io_select;
    logic       w_data_phase;
    logic       w_strobe_fall;
    logic       w_commit;
    logic [11:0] w_word;
    logic [11:0] w_src;

    assign w_addr_phase = cpu_out[7];
    assign w_addr_hi    = cpu_out[6];
    assign w_field      = cpu_out[6:5];
    assign w_strobe_n   = cpu_out[4];
    assign w_nibble     = cpu_out[3:0];

    assign w_io_select  = ~w_addr_phase & (w_field == c_F_SEL);
    assign w_data_phase = ~w_addr_phase & (w_field != c_F_SEL);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [AW-1:0]    r_addr;
    logic             r_io_mode;
    logic [SEL_W-1:0] r_io_sel;
    logic [3:0]       r_n_hi;
    logic [3:0]       r_n_mid;
    logic [11:0]      r_io_word;
    logic             r_strobe_prev;
    logic             r_mem_we;
    logic [11:0]      r_mem_wdata;
    logic             r_io_rd;
    logic             r_io_wr;
    logic [11:0]      r_io_wdata;

    // A capture or commit fires only on the high-to-low transition of S.
    // Holding S low therefore acts once.
    assign w_strobe_fall = w_data_phase & ~w_strobe_n & r_strobe_prev;
    assign w_commit      = w_strobe_fall & (w_field == c_F_LO);
    assign w_word        = {r_n_hi, r_n_mid, w_nibble};

    // Strobe history. Outside a data phase, S is not a strobe, so the history
    // is forced inactive. This makes the first low S of the next data phase
    // count as a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_strobe_prev <= 1'b1;
        end else if (w_data_phase) begin
            r_strobe_prev <= w_strobe_n;
        end else begin
            r_strobe_prev <= 1'b1;
        end
    end

    // Address assembly and target (memory / I/O) selection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_io_mode <= 1'b0;
            r_io_sel  <= '0;
        end else if (w_addr_phase) begin
            if (w_addr_hi) begin
                r_addr[11:6] <= cpu_out[5:0];
            end else begin
                r_addr[5:0]  <= cpu_out[5:0];
            end
            r_io_mode <= 1'b0;
        end else if (w_io_select) begin
            r_io_mode <= 1'b1;
            r_io_sel  <= SEL_W'(cpu_out[4:0]);
        end
    end

    // Write nibble capture. The low nibble comes directly from the bus on the
    // commit cycle, so only the upper two nibbles need holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_hi  <= 4'h0;
            r_n_mid <= 4'h0;
        end else if (w_strobe_fall) begin
            if (w_field == c_F_HI) begin
                r_n_hi <= w_nibble;
            end else if (w_field == c_F_MID) begin
                r_n_mid <= w_nibble;
            end
        end
    end

    // Write commit. The target is the io_mode value at commit time. The
    // write data registers hold their value between commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_we    <= 1'b0;
            r_io_wr     <= 1'b0;
            r_mem_wdata <= 12'h000;
            r_io_wdata  <= 12'h000;
        end else begin
            r_mem_we <= w_commit & ~r_io_mode;
            r_io_wr  <= w_commit &  r_io_mode;
            if (w_commit && !r_io_mode) begin
                r_mem_wdata <= w_word;
            end
            if (w_commit && r_io_mode) begin
                r_io_wdata <= w_word;
            end
        end
    end

    // I/O read handshake. io_rd is high for the cycle after each select, and
    // the device data is captured during that cycle. A repeated select
    // re-reads the device.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_io_rd   <= 1'b0;
            r_io_word <= 12'h000;
        end else begin
            r_io_rd <= w_io_select;
            if (r_io_rd) begin
                r_io_word <= io_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return: nibble mux built from registered state plus the
    // synchronous SRAM output
    // ------------------------------------------------------------------
    assign w_src = r_io_mode ? r_io_word : mem_rdata;

    always_comb begin
        cpu_din = 4'h0;
        if (!rst && !w_addr_phase) begin
            case (w_field)
                c_F_HI:  cpu_din = w_src[11:8];
                c_F_MID: cpu_din = w_src[7:4];
                c_F_LO:  cpu_din = w_src[3:0];
                default: cpu_din = 4'h0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign mem_addr  = r_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign io_mode   = r_io_mode;
    assign io_sel    = r_io_sel;
    assign io_rd     = r_io_rd;
    assign io_wr     = r_io_wr;
    assign io_wdata  = r_io_wdata;

endmodule
`default_nettype wire

// File: tb/tb_pdp8_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdp8_bus_responder
// Description : Directed self-checking bench for pdp8_bus_responder. It
//               includes a behavioural synchronous 4K x 12 SRAM and uses
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdp8_bus_responder;

    localparam int AW    = 12;
    localparam int SEL_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       cpu_out;
    logic [3:0]       cpu_din;
    logic [AW-1:0]    mem_addr;
    logic [11:0]      mem_rdata;
    logic             mem_we;
    logic [11:0]      mem_wdata;
    logic             io_mode;
    logic [SEL_W-1:0] io_sel;
    logic             io_rd;
    logic [11:0]      io_rdata;
    logic             io_wr;
    logic [11:0]      io_wdata;

    int errors = 0;
    int checks = 0;

    logic [11:0] sram [0:4095];

    pdp8_bus_responder #(.AW(AW), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_out   (cpu_out),
        .cpu_din   (cpu_din),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .io_mode   (io_mode),
        .io_sel    (io_sel),
        .io_rd     (io_rd),
        .io_rdata  (io_rdata),
        .io_wr     (io_wr),
        .io_wdata  (io_wdata)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: read data one cycle after address, read-before-write
    always @(posedge clk) begin
        if (mem_we) begin
            sram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= sram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int pulses;
    logic [11:0] pulse_data;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            sram[i] = 12'h000;
        end
        sram[12'o7777] = 12'o1234;   // 0x29C
        rst      = 1'b1;
        cpu_out  = 8'h00;
        io_rdata = 12'h000;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_cpu_din",  cpu_din, 4'h0);
        check("rst_mem_addr", mem_addr, 12'h000);
        check("rst_mem_we",   mem_we, 1'b0);
        check("rst_io_mode",  io_mode, 1'b0);
        check("rst_io_sel",   io_sel, 5'h00);
        check("rst_io_rd",    io_rd, 1'b0);
        check("rst_io_wr",    io_wr, 1'b0);
        rst = 1'b0;

        // ---------------- address assembly + read of 0o7777 ----------------
        cpu_out = 8'hFF; tick();          // A=1 H=1 -> upper half 0o77
        cpu_out = 8'hBF; tick();          // A=1 H=0 -> lower half 0o77
        check("addr_fff", mem_addr, 12'hFFF);
        check("addr_phase_din", cpu_din, 4'h0);
        cpu_out = 8'h10; tick();          // data phase, F=00, S high
        check("rd_hi",  cpu_din, 4'h2);
        cpu_out = 8'h30; #1;
        check("rd_mid", cpu_din, 4'h9);
        cpu_out = 8'h50; #1;
        check("rd_lo",  cpu_din, 4'hC);
        cpu_out = 8'h60; #1;              // F=11 returns zero
        check("rd_f11", cpu_din, 4'h0);
        cpu_out = 8'h10; #1;

        // ---------------- nibble write to 0x0A5 ----------------
        cpu_out = 8'hC2; tick();          // upper six bits = 2
        cpu_out = 8'hA5; tick();          // lower six bits = 0x25
        check("addr_0a5", mem_addr, 12'h0A5);
        cpu_out = 8'h0A; tick();          // F=00 strobe fall, nibble A
        cpu_out = 8'h1B; tick();
        cpu_out = 8'h2B; tick();          // F=01 strobe fall, nibble B
        check("no_we_on_mid", mem_we, 1'b0);
        cpu_out = 8'h5C; tick();
        cpu_out = 8'h4C; tick();          // F=10 strobe fall, commit
        check("wr_we",    mem_we, 1'b1);
        check("wr_wdata", mem_wdata, 12'hABC);
        check("wr_addr",  mem_addr, 12'h0A5);
        cpu_out = 8'h10; tick();
        check("wr_we_single", mem_we, 1'b0);
        tick();
        check("rb_hi",  cpu_din, 4'hA);
        cpu_out = 8'h30; #1;
        check("rb_mid", cpu_din, 4'hB);
        cpu_out = 8'h50; #1;
        check("rb_lo",  cpu_din, 4'hC);

        // ---------------- held strobe: exactly one commit ----------------
        cpu_out = 8'h5F; tick();
        cpu_out = 8'h4F;
        pulses = 0;
        pulse_data = 12'h000;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_we === 1'b1) begin
                pulses++;
                pulse_data = mem_wdata;
            end
        end
        cpu_out = 8'h5F; tick();
        if (mem_we === 1'b1) pulses++;
        check("held_pulses", pulses, 1);
        check("held_wdata",  pulse_data, 12'hABF);

        // ---------------- I/O path ----------------
        io_rdata = 12'h5A3;
        cpu_out = 8'h6B; tick();          // I/O select device 0x0B
        check("io_rd_pulse", io_rd, 1'b1);
        check("io_mode_set", io_mode, 1'b1);
        check("io_sel",      io_sel, 5'h0B);
        cpu_out = 8'h10; tick();          // io_word captured on this edge
        io_rdata = 12'hFFF;
        check("io_rd_single", io_rd, 1'b0);
        check("io_rd_hi",  cpu_din, 4'h5);
        cpu_out = 8'h30; #1;
        check("io_rd_mid", cpu_din, 4'hA);
        cpu_out = 8'h50; #1;
        check("io_rd_lo",  cpu_din, 4'h3);
        cpu_out = 8'h01; tick();          // nibble 1
        cpu_out = 8'h12; tick();
        cpu_out = 8'h22; tick();          // nibble 2
        cpu_out = 8'h53; tick();
        cpu_out = 8'h43; tick();          // commit 0x123 to the device
        check("io_wr_pulse", io_wr, 1'b1);
        check("io_wdata",    io_wdata, 12'h123);
        check("io_no_mem_we", mem_we, 1'b0);
        cpu_out = 8'h53; tick();
        check("io_wr_single", io_wr, 1'b0);
        check("io_sram_untouched", sram[12'h0A5], 12'hABF);
        cpu_out = 8'h80; tick();          // address phase clears io_mode
        check("io_mode_clear", io_mode, 1'b0);

        // ---------------- reset mid-write ----------------
        cpu_out = 8'hC2; tick();
        cpu_out = 8'hA5; tick();
        cpu_out = 8'h1D; tick();
        cpu_out = 8'h0D; tick();          // nibble D captured, later discarded
        rst = 1'b1;
        cpu_out = 8'h2E; tick();
        check("mr_mem_addr", mem_addr, 12'h000);
        check("mr_mem_we",   mem_we, 1'b0);
        check("mr_io_wr",    io_wr, 1'b0);
        check("mr_io_mode",  io_mode, 1'b0);
        check("mr_cpu_din",  cpu_din, 4'h0);
        cpu_out = 8'h4F; tick();          // commit attempt while in reset
        check("mr_no_we",    mem_we, 1'b0);
        rst = 1'b0;
        cpu_out = 8'hC2; tick();
        cpu_out = 8'hA5; tick();
        cpu_out = 8'h37; tick();
        cpu_out = 8'h27; tick();          // nibble 7 (mid)
        cpu_out = 8'h59; tick();
        cpu_out = 8'h49; tick();          // commit: hi nibble is reset 0
        check("mr_new_we",    mem_we, 1'b1);
        check("mr_new_wdata", mem_wdata, 12'h079);
        cpu_out = 8'h10; tick();
        tick();
        check("mr_rb_hi", cpu_din, 4'h0);
        cpu_out = 8'h30; #1;
        check("mr_rb_mid", cpu_din, 4'h7);
        cpu_out = 8'h50; #1;
        check("mr_rb_lo", cpu_din, 4'h9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
